// File: rtl/fsm_sequencer.sv
// fsm_sequencer: button-triggered timed-phase sequencer driving a downstream
// timer through START/RESET and stepping PHASE on each READY handshake.
module fsm_sequencer #(
  parameter  int NPHASES = 4,
  localparam int PW      = (NPHASES > 2) ? $clog2(NPHASES) : 1
) (
  input  logic          CLK,
  input  logic          N_RESET,
  input  logic          BTN,
  input  logic          TMR_READY,
  output logic          TMR_START,
  output logic          TMR_RESET,
  output logic [PW-1:0] PHASE,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_ACK,
    S_FIN,
    S_ABORT
  } state_e;

  localparam logic [PW-1:0] LAST_PHASE = PW'(NPHASES - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          s1_q, s2_q, s3_q;
  logic [2:0]    vld_q;
  logic          start_q, start_d;
  logic          treset_q, treset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          press;

  // Next-state, phase update and Moore output decode of the next state.
  always_comb begin
    // vld_q[2] marks s3 as holding a real post-reset BTN sample, so a button
    // already held at reset release never looks like a rising edge.
    press    = s2_q & ~s3_q & vld_q[2];
    state_d  = state_q;
    phase_d  = phase_q;
    case (state_q)
      S_IDLE: begin
        if (press) state_d = S_ARM;
      end
      S_ARM: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (press)          state_d = S_ABORT;
        else if (TMR_READY) state_d = S_ACK;
      end
      S_ACK: begin
        if (phase_q == LAST_PHASE) begin
          state_d = S_FIN;
        end else begin
          phase_d = phase_q + PW'(1);
          state_d = S_ARM;
        end
      end
      S_FIN, S_ABORT: begin
        phase_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        phase_d = '0;
        state_d = S_IDLE;
      end
    endcase
    start_d  = (state_d == S_ARM);
    treset_d = (state_d == S_ACK) || (state_d == S_ABORT);
    busy_d   = (state_d == S_ARM) || (state_d == S_WAIT) || (state_d == S_ACK);
    done_d   = (state_d == S_FIN);
  end

  // All state: synchroniser, FSM, phase counter and registered outputs.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      vld_q    <= '0;
      start_q  <= 1'b0;
      treset_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      s1_q     <= BTN;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      vld_q    <= {vld_q[1:0], 1'b1};
      state_q  <= state_d;
      phase_q  <= phase_d;
      start_q  <= start_d;
      treset_q <= treset_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign TMR_START = start_q;
  assign TMR_RESET = treset_q;
  assign PHASE     = phase_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Testbench for fsm_sequencer: two instances (4 and 2 phases) share all
// inputs and are checked every cycle against a run-level reference model.
module tb_fsm_sequencer;

  logic       CLK;
  logic       N_RESET;
  logic       BTN;
  logic       TMR_READY;
  logic       start4, rst4, busy4, done4;
  logic [1:0] phase4;
  logic       start2, rst2, busy2, done2;
  logic [0:0] phase2;

  fsm_sequencer #(.NPHASES(4)) u_dut4 (
    .CLK(CLK), .N_RESET(N_RESET), .BTN(BTN), .TMR_READY(TMR_READY),
    .TMR_START(start4), .TMR_RESET(rst4), .PHASE(phase4), .BUSY(busy4), .DONE(done4)
  );

  fsm_sequencer #(.NPHASES(2)) u_dut2 (
    .CLK(CLK), .N_RESET(N_RESET), .BTN(BTN), .TMR_READY(TMR_READY),
    .TMR_START(start2), .TMR_RESET(rst2), .PHASE(phase2), .BUSY(busy2), .DONE(done2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: where the run currently is and which phase it is on.
  localparam int M_IDLE  = 0;
  localparam int M_ARM   = 1;
  localparam int M_WAIT  = 2;
  localparam int M_ACK   = 3;
  localparam int M_FIN   = 4;
  localparam int M_ABORT = 5;

  typedef struct {
    int mode;
    int phase;
  } mdl_t;

  mdl_t m4, m2;
  bit   bq[$];        // BTN samples taken since reset release
  int   cyc;
  int   n_chk, n_bad;
  int   n_start4, n_done4, n_abort4;
  int   first_start;
  int   ph_seq[$];
  bit   tmr_on;
  int   tmr_cnt;
  bit   tmr_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_step(mdl_t m, bit press, bit rdy, int nph);
    mdl_t n = m;
    if (m.mode == M_IDLE) begin
      if (press) n.mode = M_ARM;
    end else if (m.mode == M_ARM) begin
      n.mode = M_WAIT;
    end else if (m.mode == M_WAIT) begin
      if (press)    n.mode = M_ABORT;
      else if (rdy) n.mode = M_ACK;
    end else if (m.mode == M_ACK) begin
      if (m.phase == nph - 1) begin
        n.mode = M_FIN;
      end else begin
        n.phase = m.phase + 1;
        n.mode  = M_ARM;
      end
    end else begin
      n.mode  = M_IDLE;
      n.phase = 0;
    end
    return n;
  endfunction

  task automatic check_dut(input string nm, input mdl_t m, input logic st, input logic rs,
                           input logic [31:0] ph, input logic bz, input logic dn);
    check({nm, "_start"}, {31'b0, st}, {31'b0, m.mode == M_ARM});
    check({nm, "_treset"}, {31'b0, rs}, {31'b0, (m.mode == M_ACK) || (m.mode == M_ABORT)});
    check({nm, "_phase"}, ph, m.phase);
    check({nm, "_busy"}, {31'b0, bz},
          {31'b0, (m.mode == M_ARM) || (m.mode == M_WAIT) || (m.mode == M_ACK)});
    check({nm, "_done"}, {31'b0, dn}, {31'b0, m.mode == M_FIN});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start4"}, {31'b0, start4}, 0);
    check({tag, "_treset4"}, {31'b0, rst4}, 0);
    check({tag, "_busy4"}, {31'b0, busy4}, 0);
    check({tag, "_done4"}, {31'b0, done4}, 0);
    check({tag, "_phase4"}, {30'b0, phase4}, 0);
    check({tag, "_start2"}, {31'b0, start2}, 0);
    check({tag, "_treset2"}, {31'b0, rst2}, 0);
    check({tag, "_busy2"}, {31'b0, busy2}, 0);
    check({tag, "_done2"}, {31'b0, done2}, 0);
    check({tag, "_phase2"}, {31'b0, phase2}, 0);
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare at negedge.
  task automatic tick(input bit b, input bit r);
    bit prs;
    int sz;
    BTN       = b;
    TMR_READY = r;
    @(posedge CLK);
    sz  = bq.size();
    prs = (sz >= 3) && bq[sz-2] && !bq[sz-3];
    m4  = mdl_step(m4, prs, r, 4);
    m2  = mdl_step(m2, prs, r, 2);
    bq.push_back(b);
    if (bq.size() > 4) void'(bq.pop_front());
    cyc++;
    @(negedge CLK);
    check_dut("p4", m4, start4, rst4, {30'b0, phase4}, busy4, done4);
    check_dut("p2", m2, start2, rst2, {31'b0, phase2}, busy2, done2);
    if (start4 === 1'b1) begin
      n_start4++;
      ph_seq.push_back(int'(phase4));
      if (first_start < 0) first_start = cyc;
    end
    if (done4 === 1'b1) n_done4++;
    if (rst4 === 1'b1 && busy4 === 1'b0) n_abort4++;
    // Downstream timer stand-in: READY after 4 cycles, held until TMR_RESET.
    if (start4 === 1'b1) begin
      tmr_on  = 1'b1;
      tmr_cnt = 4;
    end else if (rst4 === 1'b1) begin
      tmr_on = 1'b0;
    end else if (tmr_on && tmr_cnt > 0) begin
      tmr_cnt--;
    end
    tmr_ready = tmr_on && (tmr_cnt == 0);
  endtask

  task automatic run(input bit b, input int n);
    for (int i = 0; i < n; i++) tick(b, tmr_ready);
  endtask

  task automatic clr_cnt();
    n_start4    = 0;
    n_done4     = 0;
    n_abort4    = 0;
    first_start = -1;
    ph_seq.delete();
  endtask

  // Asynchronous reset pulse starting mid-cycle; released on a falling edge.
  task automatic do_reset(input string tag);
    #2 N_RESET = 1'b0;
    #1 check_all_zero({tag, "_async"});
    @(negedge CLK);
    @(negedge CLK);
    check_all_zero({tag, "_held"});
    N_RESET  = 1'b1;
    m4.mode  = M_IDLE;
    m4.phase = 0;
    m2.mode  = M_IDLE;
    m2.phase = 0;
    bq.delete();
    tmr_on    = 1'b0;
    tmr_cnt   = 0;
    tmr_ready = 1'b0;
  endtask

  task automatic wait_start_phase(input int ph);
    int k = 0;
    while (!(start4 === 1'b1 && int'(phase4) == ph) && k < 100) begin
      tick(1'b0, tmr_ready);
      k++;
    end
    check("wait_start_timeout", {31'b0, k < 100}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit rb;
    N_RESET   = 1'b0;
    BTN       = 1'b0;
    TMR_READY = 1'b0;
    n_chk     = 0;
    n_bad     = 0;
    cyc       = 0;
    clr_cnt();
    @(negedge CLK);
    do_reset("init");
    run(1'b0, 4);

    // Full run: four phases, one DONE, back to idle at phase 0.
    clr_cnt();
    run(1'b1, 3);
    run(1'b0, 60);
    check("run_starts", n_start4, 4);
    check("run_dones", n_done4, 1);
    check("run_seq_len", ph_seq.size(), 4);
    for (int i = 0; i < ph_seq.size(); i++) check("run_seq", ph_seq[i], i);
    check("run_end_phase", {30'b0, phase4}, 0);
    check("run_end_busy", {31'b0, busy4}, 0);

    // Held button: one run only, START two edges after the first high sample.
    clr_cnt();
    run(1'b0, 2);
    begin
      int e0;
      e0 = cyc + 1;
      run(1'b1, 50);
      check("hold_latency", first_start - e0, 2);
    end
    run(1'b0, 10);
    check("hold_starts", n_start4, 4);
    check("hold_dones", n_done4, 1);

    // Press while waiting in phase 2 aborts the run.
    clr_cnt();
    run(1'b1, 2);
    wait_start_phase(2);
    tick(1'b1, tmr_ready);
    run(1'b1, 2);
    run(1'b0, 12);
    check("abort_count", n_abort4, 1);
    check("abort_dones", n_done4, 0);
    check("abort_phase", {30'b0, phase4}, 0);
    check("abort_busy", {31'b0, busy4}, 0);

    // Press and READY in the same cycle while waiting: abort wins.
    clr_cnt();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("both_treset", {31'b0, rst4}, 1);
    check("both_busy", {31'b0, busy4}, 0);
    run(1'b0, 8);
    check("both_abort", n_abort4, 1);
    check("both_dones", n_done4, 0);

    // Reset mid-wait in phase 1; button held through release must not start.
    clr_cnt();
    run(1'b1, 2);
    wait_start_phase(1);
    tick(1'b0, tmr_ready);
    BTN = 1'b1;
    do_reset("midrun");
    clr_cnt();
    run(1'b1, 20);
    check("held_release_starts", n_start4, 0);
    run(1'b0, 3);
    run(1'b1, 2);
    run(1'b0, 40);
    check("fresh_press_starts", n_start4, 4);
    check("fresh_press_dones", n_done4, 1);

    // Random button activity, noisy READY and occasional async resets.
    rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rb = !rb;
      if ($urandom_range(0, 599) == 0) do_reset("rand");
      else tick(rb, tmr_ready ^ ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
